// File: rtl/vecmac_dot_sequencer.sv
// Dot-product sequencer: streams operand words into a 4x8x8 multiplier and accumulates lane sums.
// Optional build macro VECMAC_SAT_EN: saturating accumulator with an ovf output.
module vecmac_dot_sequencer #(
   parameter int ACC_W   = 32,
   parameter int LEN_W   = 16,
   parameter int MAX_OUT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   input  logic             op_valid,
   input  logic [31:0]      op_a,
   input  logic [31:0]      op_b,
   output logic             op_ready,
   output logic             mul_in_valid,
   output logic [31:0]      mul_in_a,
   output logic [31:0]      mul_in_b,
   input  logic             mul_out_valid,
   input  logic [17:0]      mul_out_sum,
   output logic             res_valid,
   output logic [ACC_W-1:0] res_data,
   input  logic             res_ready
`ifdef VECMAC_SAT_EN
   ,
   output logic             ovf
`endif
);

   localparam int OW = $clog2(MAX_OUT + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t           state_q;
   logic [LEN_W-1:0] len_q, issued_q, received_q, received_d;
   logic [OW-1:0]    outst_q, outst_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W:0]   sum_w;
   logic             mul_in_valid_q, res_valid_q;
   logic [31:0]      mul_in_a_q, mul_in_b_q;
   logic [ACC_W-1:0] res_data_q;
   logic             accept, ret;
`ifdef VECMAC_SAT_EN
   logic             ovf_q, ovf_d;
`endif

   assign op_ready = (state_q == RUN) && (issued_q < len_q) && (outst_q < OW'(MAX_OUT));
   assign accept   = op_valid && op_ready;
   assign ret      = mul_out_valid && (state_q == RUN);

   always_comb begin
      sum_w      = {1'b0, acc_q} + {{(ACC_W + 1 - 18){1'b0}}, mul_out_sum};
      received_d = received_q + LEN_W'(1);
`ifdef VECMAC_SAT_EN
      // Once saturated, the accumulator is pinned for the rest of the job.
      if (ovf_q || sum_w[ACC_W]) begin
         acc_d = '1;
         ovf_d = 1'b1;
      end else begin
         acc_d = sum_w[ACC_W-1:0];
         ovf_d = ovf_q;
      end
`else
      acc_d = sum_w[ACC_W-1:0];
`endif
      case ({accept, ret})
         2'b10:   outst_d = outst_q + OW'(1);
         2'b01:   outst_d = outst_q - OW'(1);
         default: outst_d = outst_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         len_q          <= '0;
         issued_q       <= '0;
         received_q     <= '0;
         outst_q        <= '0;
         acc_q          <= '0;
         mul_in_valid_q <= 1'b0;
         mul_in_a_q     <= '0;
         mul_in_b_q     <= '0;
         res_valid_q    <= 1'b0;
         res_data_q     <= '0;
`ifdef VECMAC_SAT_EN
         ovf_q          <= 1'b0;
`endif
      end else begin
         mul_in_valid_q <= accept;
         mul_in_a_q     <= accept ? op_a : 32'd0;
         mul_in_b_q     <= accept ? op_b : 32'd0;
         case (state_q)
            IDLE: begin
               if (start) begin
`ifdef VECMAC_SAT_EN
                  ovf_q <= 1'b0;
`endif
                  if (len == '0) begin
                     state_q     <= DONE;
                     res_valid_q <= 1'b1;
                     res_data_q  <= '0;
                  end else begin
                     state_q    <= RUN;
                     len_q      <= len;
                     acc_q      <= '0;
                     issued_q   <= '0;
                     received_q <= '0;
                     outst_q    <= '0;
                  end
               end
            end
            RUN: begin
               if (accept) issued_q <= issued_q + LEN_W'(1);
               outst_q <= outst_d;
               if (ret) begin
                  acc_q      <= acc_d;
                  received_q <= received_d;
`ifdef VECMAC_SAT_EN
                  ovf_q      <= ovf_d;
`endif
                  // Final result leaves on the same edge as the last accumulate.
                  if (received_d == len_q) begin
                     state_q     <= DONE;
                     res_valid_q <= 1'b1;
                     res_data_q  <= acc_d;
                  end
               end
            end
            DONE: begin
               if (res_ready) begin
                  state_q     <= IDLE;
                  res_valid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy         = (state_q != IDLE);
   assign mul_in_valid = mul_in_valid_q;
   assign mul_in_a     = mul_in_a_q;
   assign mul_in_b     = mul_in_b_q;
   assign res_valid    = res_valid_q;
   assign res_data     = res_data_q;
`ifdef VECMAC_SAT_EN
   assign ovf          = ovf_q;
`endif

endmodule

// File: tb/tb_vecmac_dot_sequencer.sv
// Bench for vecmac_dot_sequencer: table-driven jobs, scoreboard on results, latency-6 multiplier model.
module tb_vecmac_dot_sequencer;
   localparam int LAT  = 6;
   localparam int MAXO = 4;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, op_valid = 1'b0, res_ready = 1'b1;
   logic [15:0] len = '0;
   logic [31:0] op_a = '0, op_b = '0;
   logic        busy, op_ready, miv, mov, rv;
   logic [31:0] mia, mib, rd;
   logic [17:0] mos;
   logic        busy18, rdy18, miv18, rv18;
   logic [31:0] mia18, mib18;
   logic [17:0] rd18;
`ifdef VECMAC_SAT_EN
   logic        ovf32, ovf18;
`endif

   always #5 clk = ~clk;

   vecmac_dot_sequencer #(.ACC_W(32), .LEN_W(16), .MAX_OUT(MAXO)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
      .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
      .mul_in_valid(miv), .mul_in_a(mia), .mul_in_b(mib),
      .mul_out_valid(mov), .mul_out_sum(mos),
      .res_valid(rv), .res_data(rd), .res_ready(res_ready)
`ifdef VECMAC_SAT_EN
      , .ovf(ovf32)
`endif
   );

   // Narrow-accumulator twin; control is width-independent so it shares the multiplier model.
   vecmac_dot_sequencer #(.ACC_W(18), .LEN_W(16), .MAX_OUT(MAXO)) dut18 (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy18),
      .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(rdy18),
      .mul_in_valid(miv18), .mul_in_a(mia18), .mul_in_b(mib18),
      .mul_out_valid(mov), .mul_out_sum(mos),
      .res_valid(rv18), .res_data(rd18), .res_ready(res_ready)
`ifdef VECMAC_SAT_EN
      , .ovf(ovf18)
`endif
   );

   function automatic logic [17:0] lsum(input logic [31:0] a, input logic [31:0] b);
      logic [17:0] s;
      s = '0;
      for (int k = 0; k < 4; k++) s = s + 18'(a[8*k +: 8]) * 18'(b[8*k +: 8]);
      return s;
   endfunction

   logic [LAT-1:0] mv_pipe;
   logic [17:0]    ms_pipe [LAT];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mv_pipe <= '0;
         for (int i = 0; i < LAT; i++) ms_pipe[i] <= '0;
      end else begin
         mv_pipe    <= {mv_pipe[LAT-2:0], miv};
         ms_pipe[0] <= lsum(mia, mib);
         for (int i = 1; i < LAT; i++) ms_pipe[i] <= ms_pipe[i-1];
      end
   end
   assign mov = mv_pipe[LAT-1];
   assign mos = ms_pipe[LAT-1];

   int tb_out;
   always @(posedge clk or posedge rst) begin
      if (rst) tb_out <= 0;
      else     tb_out <= tb_out + int'(op_valid && op_ready) - int'(mov);
   end

   int n_tests = 0, n_fail = 0;
   int issue_cnt = 0;
   bit rdy_seen = 0, saw_full = 0, ovr_err = 0;
   logic [31:0] exp_q[$];
   logic [31:0] wa[$], wb[$];
   logic [17:0] last18 = '0;
   logic        last_ovf18 = 1'b0, last_ovf32 = 1'b0;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (!rst) begin
         if (miv) issue_cnt++;
         if (op_ready) rdy_seen = 1;
         if (tb_out == MAXO) saw_full = 1;
         if (tb_out > MAXO || (tb_out >= MAXO && op_ready)) ovr_err = 1;
         if (rv && res_ready) begin
            if (exp_q.size() == 0) chk("res_unexpected", 1, 0);
            else chk("res_data", {32'd0, rd}, {32'd0, exp_q.pop_front()});
         end
         if (rv18 && res_ready) begin
            last18 = rd18;
`ifdef VECMAC_SAT_EN
            last_ovf18 = ovf18;
            last_ovf32 = ovf32;
`endif
         end
      end
   end

   task automatic run_job(input int n, input logic [31:0] e, input bit tog);
      int i, g;
      bit ph;
      issue_cnt = 0; rdy_seen = 0; saw_full = 0;
      exp_q.push_back(e);
      @(negedge clk); start = 1'b1; len = 16'(n);
      @(negedge clk); start = 1'b0;
      i = 0; g = 0; ph = 0;
      while (i < n && g < 2000) begin
         if (tog && ph) op_valid = 1'b0;
         else begin
            op_valid = 1'b1; op_a = wa[i]; op_b = wb[i];
         end
         ph = !ph;
         if (op_valid && op_ready) i++;
         @(negedge clk); g++;
      end
      op_valid = 1'b0;
      chk("words_accepted", 64'(i), 64'(n));
      g = 0;
      while (busy && g < 500) begin @(negedge clk); g++; end
      chk("job_done_busy", {63'd0, busy}, 0);
      chk("issue_count", 64'(issue_cnt), 64'(n));
   endtask

   typedef struct {
      int          n;
      logic [31:0] a, b;
      bit          tog;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[4];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] held, e;
      int g, n;
      tbl[0] = '{1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0003F804};
      tbl[1] = '{4, 32'h01010101, 32'h02020202, 1'b1, 32'h00000020};
      tbl[2] = '{8, 32'h01020304, 32'h05060708, 1'b0, 32'h00000230};
      tbl[3] = '{3, 32'hFFFFFFFF, 32'h01010101, 1'b1, 32'h00000BF4};

      repeat (2) @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 0);
      chk("rst_op_ready", {63'd0, op_ready}, 0);
      chk("rst_mul_in_valid", {63'd0, miv}, 0);
      chk("rst_mul_in_a", {32'd0, mia}, 0);
      chk("rst_res_valid", {63'd0, rv}, 0);
      chk("rst_res_data", {32'd0, rd}, 0);
      rst = 1'b0;

      for (int j = 0; j < 4; j++) begin
         wa.delete(); wb.delete();
         for (int k = 0; k < tbl[j].n; k++) begin wa.push_back(tbl[j].a); wb.push_back(tbl[j].b); end
         run_job(tbl[j].n, tbl[j].exp, tbl[j].tog);
         if (tbl[j].n == 8) chk("max_out_reached", {63'd0, saw_full}, 1);
      end

      // Zero-length job: result one cycle after start, nothing issued.
      issue_cnt = 0; rdy_seen = 0;
      exp_q.push_back(32'd0);
      @(negedge clk); start = 1'b1; len = 16'd0;
      @(negedge clk); start = 1'b0;
      chk("len0_res_valid", {63'd0, rv}, 1);
      chk("len0_res_data", {32'd0, rd}, 0);
      @(negedge clk);
      chk("len0_busy_after", {63'd0, busy}, 0);
      chk("len0_no_ready", {63'd0, rdy_seen}, 0);
      chk("len0_no_issue", 64'(issue_cnt), 0);

      // Held result with a start pulse that must be ignored.
      res_ready = 1'b0; issue_cnt = 0;
      exp_q.push_back(32'h0003F804);
      @(negedge clk); start = 1'b1; len = 16'd1;
      @(negedge clk); start = 1'b0; op_valid = 1'b1; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
      @(negedge clk); op_valid = 1'b0;
      g = 0;
      while (!rv && g < 100) begin @(negedge clk); g++; end
      chk("hold_res_valid", {63'd0, rv}, 1);
      held = rd;
      for (int c = 0; c < 5; c++) begin
         start = (c == 1); len = 16'd3;
         @(negedge clk);
         chk("hold_valid_stable", {63'd0, rv}, 1);
         chk("hold_data_stable", {32'd0, rd}, {32'd0, held});
      end
      start = 1'b0; res_ready = 1'b1;
      @(negedge clk);
      chk("hold_busy_after", {63'd0, busy}, 0);
      repeat (2) @(negedge clk);
      chk("start_ignored_busy", {63'd0, busy}, 0);
      chk("start_ignored_issue", 64'(issue_cnt), 1);

      // Two max-product words: wraps in the 18-bit twin, not in the 32-bit DUT.
      wa = '{32'hFFFFFFFF, 32'hFFFFFFFF}; wb = '{32'hFFFFFFFF, 32'hFFFFFFFF};
      run_job(2, 32'h0007F008, 1'b0);
`ifdef VECMAC_SAT_EN
      chk("acc18_sat", {46'd0, last18}, 64'h3FFFF);
      chk("ovf18_set", {63'd0, last_ovf18}, 1);
      chk("ovf32_clear", {63'd0, last_ovf32}, 0);
`else
      chk("acc18_wrap", {46'd0, last18}, 64'h3F008);
`endif

      // Random jobs through the scoreboard.
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, 12);
         wa.delete(); wb.delete(); e = '0;
         for (int k = 0; k < n; k++) begin
            wa.push_back($urandom); wb.push_back($urandom);
            e = e + 32'(lsum(wa[k], wb[k]));
         end
         run_job(n, e, r[0]);
      end

      // Reset in the middle of a job aborts everything.
      @(negedge clk); start = 1'b1; len = 16'd8;
      @(negedge clk); start = 1'b0; op_valid = 1'b1; op_a = 32'h11111111; op_b = 32'h22222222;
      repeat (3) @(negedge clk);
      rst = 1'b1; #1;
      chk("midrst_busy", {63'd0, busy}, 0);
      chk("midrst_op_ready", {63'd0, op_ready}, 0);
      chk("midrst_mul_in_valid", {63'd0, miv}, 0);
      chk("midrst_res_valid", {63'd0, rv}, 0);
      op_valid = 1'b0;
      @(negedge clk); rst = 1'b0;
      wa = '{32'hFFFFFFFF}; wb = '{32'hFFFFFFFF};
      run_job(1, 32'h0003F804, 1'b0);

      chk("no_overrun", {63'd0, ovr_err}, 0);
      chk("scoreboard_empty", 64'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
